mean_threshold: RTL and testbench

Frame-level binarization stage that runs after the blur pass and before the final display state. When the top-level FSM holds `i_start` high, it owns the shared SRAM port and runs two passes. Pass 1 reads every RGB565 pixel and accumulates its 8-bit luma. A sequential divide then produces the frame mean. Pass 2 rewrites every pixel in place as 16'hFFFF if its luma is at least the mean, otherwise 16'h0000.

---
 rtl/img_pkg.sv | 40 ++++
 rtl/seq_div.sv | 79 +++++++
 rtl/mean_threshold.sv | 158 +++++++++++++++
 tb/tb_mean_threshold.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: frame geometry, SRAM bus widths,
// BT.601-style luma coefficients (scaled by 256), the mean_threshold FSM
// state type and an RGB565 luma helper.
package img_pkg;

    localparam int unsigned PIX_W   = 16;
    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned FRAME_W = 640;
    localparam int unsigned FRAME_H = 480;

    localparam logic [15:0] LUMA_R = 16'd77;
    localparam logic [15:0] LUMA_G = 16'd150;
    localparam logic [15:0] LUMA_B = 16'd29;

    typedef enum logic [2:0] {
        MT_IDLE,
        MT_P1_ADDR,
        MT_P1_CAP,
        MT_DIV,
        MT_P2_ADDR,
        MT_P2_CAP,
        MT_P2_WR,
        MT_DONE
    } mt_state_e;

    // 8-bit luma of an RGB565 pixel; channels widened by replicating their MSBs.
    // Coefficients sum to 256, so the weighted sum never exceeds 16 bits.
    function automatic logic [7:0] luma(input logic [PIX_W-1:0] px);
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [15:0] sum;
        r8  = {px[15:11], px[15:13]};
        g8  = {px[10:5],  px[10:9]};
        b8  = {px[4:0],   px[4:2]};
        sum = LUMA_R * 16'(r8) + LUMA_G * 16'(g8) + LUMA_B * 16'(b8);
        return 8'(sum >> 8);
    endfunction

endpackage

// File: rtl/seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Ports: i_clk, i_rst_n (async active-low), i_start (one-cycle load strobe),
//        i_dividend, i_divisor, o_quotient (valid when o_done pulses),
//        o_done (one-cycle pulse W cycles after the start edge).
module seq_div #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_quotient,
    output logic         o_done
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W:0]       trial_c;

    // One restoring step per cycle; the dividend shifts out of quo as quotient bits shift in.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        trial_c = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};
        if (i_start) begin
            rem_d  = '0;
            quo_d  = i_dividend;
            dvs_d  = i_divisor;
            cnt_d  = CNT_W'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!trial_c[W]) begin
                rem_d = trial_c[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = {rem_q[W-2:0], quo_q[W-1]};
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign o_quotient = quo_q;
    assign o_done     = done_q;

endmodule

// File: rtl/mean_threshold.sv
// Frame binarization: pass 1 sums pixel luma, a sequential divide yields the
// frame mean, pass 2 rewrites each pixel in place as white (luma >= mean) or black.
// Ports: i_clk, i_rst_n (async active-low), i_start (level enable, held for the job),
//        i_sram_rdata (read data), o_sram_addr / o_sram_we / o_sram_wdata (SRAM port),
//        o_finished (high from DONE until i_start drops).
module mean_threshold
    import img_pkg::*;
#(
    parameter int unsigned       N_PIXELS  = FRAME_W * FRAME_H,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       ACC_W     = $clog2(N_PIXELS * 255 + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [PIX_W-1:0]  i_sram_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we,
    output logic [PIX_W-1:0]  o_sram_wdata,
    output logic              o_finished
);

    localparam int unsigned      IDX_W    = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIXELS - 1);

    mt_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]        mean_q, mean_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [PIX_W-1:0]  wdata_q, wdata_d;
    logic              fin_q, fin_d;

    logic              div_start_c;
    logic              div_done;
    logic [ACC_W-1:0]  div_quo;
    logic [7:0]        y_c;
    logic              last_c;
    logic [IDX_W-1:0]  idx_inc_c;

    assign y_c       = luma(i_sram_rdata);
    assign last_c    = (idx_q == LAST_IDX);
    assign idx_inc_c = idx_q + IDX_W'(1);

    // Divider is launched on the last pass-1 capture with the final sum, so the
    // quotient lands exactly as DIV completes its ACC_W+1 cycles.
    seq_div #(
        .W (ACC_W)
    ) u_div (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (div_start_c),
        .i_dividend (acc_d),
        .i_divisor  (ACC_W'(N_PIXELS)),
        .o_quotient (div_quo),
        .o_done     (div_done)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        mean_d      = mean_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        wdata_d     = wdata_q;
        fin_d       = 1'b0;
        div_start_c = 1'b0;

        if (!i_start && state_q != MT_IDLE && state_q != MT_DONE) begin
            state_d = MT_IDLE;
        end else begin
            case (state_q)
                MT_IDLE: begin
                    idx_d = '0;
                    acc_d = '0;
                    if (i_start) begin
                        addr_d  = BASE_ADDR;
                        state_d = MT_P1_ADDR;
                    end
                end
                MT_P1_ADDR: state_d = MT_P1_CAP;
                MT_P1_CAP: begin
                    acc_d = acc_q + ACC_W'(y_c);
                    if (last_c) begin
                        idx_d       = '0;
                        div_start_c = 1'b1;
                        state_d     = MT_DIV;
                    end else begin
                        idx_d   = idx_inc_c;
                        addr_d  = BASE_ADDR + ADDR_W'(idx_inc_c);
                        state_d = MT_P1_ADDR;
                    end
                end
                MT_DIV: begin
                    if (div_done) begin
                        mean_d  = (div_quo > ACC_W'(255)) ? 8'hFF : div_quo[7:0];
                        addr_d  = BASE_ADDR;
                        state_d = MT_P2_ADDR;
                    end
                end
                MT_P2_ADDR: state_d = MT_P2_CAP;
                MT_P2_CAP: begin
                    wdata_d = (y_c >= mean_q) ? 16'hFFFF : 16'h0000;
                    we_d    = 1'b1;
                    state_d = MT_P2_WR;
                end
                MT_P2_WR: begin
                    if (last_c) begin
                        state_d = MT_DONE;
                    end else begin
                        idx_d   = idx_inc_c;
                        addr_d  = BASE_ADDR + ADDR_W'(idx_inc_c);
                        state_d = MT_P2_ADDR;
                    end
                end
                MT_DONE: begin
                    fin_d = i_start;
                    if (!i_start) begin
                        state_d = MT_IDLE;
                    end
                end
                default: state_d = MT_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= MT_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            mean_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            mean_q  <= mean_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            fin_q   <= fin_d;
        end
    end

    assign o_sram_addr  = addr_q;
    // Gated by i_start so an abort drops the strobe within the same cycle.
    assign o_sram_we    = we_q & i_start;
    assign o_sram_wdata = wdata_q;
    assign o_finished   = fin_q;

endmodule

// File: tb/tb_mean_threshold.sv
// Bench for mean_threshold with a 4-pixel frame at a non-zero base address and
// an asynchronous SRAM model; results are compared with a luma/mean reference.
module tb_mean_threshold;

    localparam int unsigned N       = 4;
    localparam int unsigned ACC_W   = $clog2(N * 255 + 1);
    localparam logic [19:0] BASE    = 20'd8;
    localparam int          FIN_LAT = 5 * N + ACC_W + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] rdata;
    logic [19:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic        fin;

    logic [15:0] mem [16];
    logic [15:0] frame [N];
    logic [15:0] exp_px [N];
    logic        load_req = 1'b0;
    int          wr_cnt = 0;
    int          bad_wr = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mean_threshold #(
        .N_PIXELS  (N),
        .BASE_ADDR (BASE)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_sram_rdata (rdata),
        .o_sram_addr  (addr),
        .o_sram_we    (we),
        .o_sram_wdata (wdata),
        .o_finished   (fin)
    );

    // Asynchronous SRAM: combinational read, write captured at the clock edge.
    assign rdata = mem[addr[3:0]];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[4'(BASE + i)] <= frame[i];
        end else if (we) begin
            mem[addr[3:0]] <= wdata;
            wr_cnt <= wr_cnt + 1;
            if (addr < BASE || addr >= BASE + N) bad_wr <= bad_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_luma(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    function automatic void build_expect();
        int sum, mean;
        sum = 0;
        for (int i = 0; i < N; i++) sum += ref_luma(frame[i]);
        mean = sum / N;
        for (int i = 0; i < N; i++) exp_px[i] = (ref_luma(frame[i]) >= mean) ? 16'hFFFF : 16'h0000;
    endfunction

    function automatic void set_frame(input int k);
        case (k)
            0:       frame = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
            1:       frame = '{16'h8410, 16'h8410, 16'h8410, 16'h8410};
            2:       frame = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
            default: for (int i = 0; i < N; i++) frame[i] = 16'($urandom);
        endcase
    endfunction

    task automatic load_mem();
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    // Caller has raised start after the previous edge; the next edge samples it.
    task automatic run_to_done(input string tag);
        int cyc;
        bit seen;
        @(posedge clk);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (fin) seen = 1'b1;
        end
        chk({tag, "_fin_latency"}, cyc, FIN_LAT);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_px%0d", tag, i), mem[4'(BASE + i)], exp_px[i]);
    endtask

    initial begin
        int base_wr, nw, cyc, we_seen, fin_seen;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", addr, 0);
        chk("rst_we", we, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_fin", fin, 0);
        rst_n = 1'b1;

        // Back-to-back jobs: directed frames then random ones, start re-raised right after IDLE.
        set_frame(0);
        load_mem();
        for (int k = 0; k < 7; k++) begin
            build_expect();
            base_wr = wr_cnt;
            start   = 1'b1;
            run_to_done($sformatf("job%0d", k));
            check_mem($sformatf("job%0d", k));
            chk($sformatf("job%0d_writes", k), wr_cnt - base_wr, N);
            base_wr = wr_cnt;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                chk($sformatf("job%0d_hold%0d", k, c), fin, 1);
            end
            chk($sformatf("job%0d_hold_writes", k), wr_cnt - base_wr, 0);
            if (k < 6) begin
                set_frame(k + 1);
                load_mem();
            end
            start = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("job%0d_fin_drop", k), fin, 0);
        end
        chk("out_of_frame_writes", bad_wr, 0);

        // Abort one cycle after the second pass-2 write.
        set_frame(2);
        load_mem();
        build_expect();
        start = 1'b1;
        nw    = 0;
        cyc   = 0;
        while (nw < 2 && cyc < 200) begin
            @(negedge clk);
            if (we) nw++;
            @(posedge clk);
            cyc++;
        end
        #1 start = 1'b0;
        chk("abort_two_writes", nw, 2);
        we_seen  = 0;
        fin_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (we) we_seen++;
            if (fin) fin_seen++;
        end
        chk("abort_we_after", we_seen, 0);
        chk("abort_fin_after", fin_seen, 0);
        chk("abort_px0", mem[4'(BASE)], exp_px[0]);
        chk("abort_px1", mem[4'(BASE + 1)], exp_px[1]);
        chk("abort_px2", mem[4'(BASE + 2)], frame[2]);
        chk("abort_px3", mem[4'(BASE + 3)], frame[3]);

        // Abort inside the first pass-2 write cycle: strobe must drop at once.
        set_frame(0);
        load_mem();
        start = 1'b1;
        @(posedge clk);
        repeat (2 * N + ACC_W + 3) @(posedge clk);
        #1;
        chk("abort_wr_we_before", we, 1);
        start = 1'b0;
        #1;
        chk("abort_wr_we_forced", we, 0);
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            chk($sformatf("abort_wr_px%0d", i), mem[4'(BASE + i)], frame[i]);

        // Reset in the middle of the divide, then rerun with start held high.
        set_frame(5);
        load_mem();
        build_expect();
        start = 1'b1;
        @(posedge clk);
        repeat (2 * N + 2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_we", we, 0);
        chk("mid_rst_wdata", wdata, 0);
        chk("mid_rst_fin", fin, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        base_wr = wr_cnt;
        run_to_done("rerun");
        check_mem("rerun");
        chk("rerun_writes", wr_cnt - base_wr, N);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("rerun_fin_drop", fin, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
